// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-lite control unit: states, opcodes,
// datapath select codes and the per-state registered control word.
package mc_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADDR  = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXEC     = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      TRAP     = 4'd11,
      FAULT    = 4'd12
   } mc_state_t;

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_LW   = 6'd35;
   localparam logic [5:0] OP_SW   = 6'd43;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_NORI = 6'd13;
   localparam logic [5:0] OP_JAL  = 6'd3;
   localparam logic [5:0] OP_JSP  = 6'd18;
   localparam logic [5:0] OP_BGTZ = 6'd38;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_NORI  = 2'b11;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_STACK  = 2'b11;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       brtype;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       regdest;
      logic       link;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       illegal;
      logic       fault;
   } ctrl_t;

   function automatic logic is_mem_state(input mc_state_t s);
      return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
   endfunction

   // Moore part of the control word; op is stable from DECODE on, so it is
   // valid whenever a state that depends on it is being entered.
   function automatic ctrl_t state_ctrl(input mc_state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.memread = 1'b1;
            c.alusrcb = SRCB_FOUR;
            c.aluop   = ALU_ADD;
            c.pcsource = PC_ALU;
         end
         DECODE: c.alusrcb = SRCB_IMMSH2;
         MEMADDR: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
         end
         MEMREAD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         MEMWRITE: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         EXEC: begin
            c.alusrca = 1'b1;
            if (op == OP_NORI) begin
               c.alusrcb = SRCB_IMM;
               c.aluop   = ALU_NORI;
            end else begin
               c.alusrcb = SRCB_B;
               c.aluop   = ALU_FUNCT;
            end
         end
         ALUWB: begin
            c.regwrite = 1'b1;
            c.regdest  = (op == OP_R);
         end
         BRANCH: begin
            c.alusrca     = 1'b1;
            c.alusrcb     = SRCB_B;
            c.aluop       = ALU_SUB;
            c.pcwritecond = 1'b1;
            c.pcsource    = PC_ALUOUT;
            c.brtype      = (op == OP_BGTZ);
         end
         JUMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = (op == OP_JSP) ? PC_STACK : PC_JUMP;
            c.regwrite = (op == OP_JAL);
            c.link     = (op == OP_JAL);
         end
         TRAP:    c.illegal = 1'b1;
         FAULT:   c.fault   = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating memory-wait counter; expired is combinational from the count.
// Clear has priority over count; MEM_TIMEOUT=0 never expires.
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNTW        = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CNTW-1:0] LIMIT = CNTW'(MEM_TIMEOUT);

   logic [CNTW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CNTW'(1);
      end
   end

   assign expired = (MEM_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-lite control FSM: registered Moore controls, Mealy irwrite/pcwrite in FETCH.
// Memory states hold until mem_ready; a wait longer than MEM_TIMEOUT cycles traps to FAULT.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int EN_EXT      = 1,
   parameter int CNTW        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       brtype,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       regdest,
   output logic       link,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsource,
   output logic       illegal,
   output logic       fault,
   output logic [3:0] state
);

   mc_state_t cur, nxt;
   ctrl_t     ctl;
   logic      expired;
   logic      cnt_clr;
   logic      cnt_en;
   logic      in_fetch;

   always_comb begin
      nxt = IDLE;
      case (cur)
         IDLE:  nxt = FETCH;
         FETCH: begin
            if (mem_ready)    nxt = DECODE;
            else if (expired) nxt = FAULT;
            else              nxt = FETCH;
         end
         DECODE: begin
            case (op)
               OP_LW, OP_SW:   nxt = MEMADDR;
               OP_R, OP_NORI:  nxt = EXEC;
               OP_BEQ:         nxt = BRANCH;
               OP_BGTZ:        nxt = (EN_EXT != 0) ? BRANCH : TRAP;
               OP_JAL, OP_JSP: nxt = (EN_EXT != 0) ? JUMP : TRAP;
               default:        nxt = TRAP;
            endcase
         end
         MEMADDR: nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD: begin
            if (mem_ready)    nxt = MEMWB;
            else if (expired) nxt = FAULT;
            else              nxt = MEMREAD;
         end
         MEMWB: nxt = FETCH;
         MEMWRITE: begin
            if (mem_ready)    nxt = FETCH;
            else if (expired) nxt = FAULT;
            else              nxt = MEMWRITE;
         end
         EXEC:    nxt = ALUWB;
         ALUWB:   nxt = FETCH;
         BRANCH:  nxt = FETCH;
         JUMP:    nxt = FETCH;
         TRAP:    nxt = TRAP;
         FAULT:   nxt = FAULT;
         default: nxt = IDLE;
      endcase
   end

   // Counter restarts whenever a memory state is freshly entered, including MEMWRITE -> FETCH.
   assign cnt_clr = is_mem_state(nxt) && (nxt != cur);
   assign cnt_en  = is_mem_state(cur) && !mem_ready;

   mc_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNTW       (CNTW)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .expired(expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur <= IDLE;
         ctl <= '0;
      end else begin
         cur <= nxt;
         ctl <= state_ctrl(nxt, op);
      end
   end

   assign in_fetch    = (cur == FETCH);
   assign irwrite     = in_fetch && mem_ready;
   assign pcwrite     = ctl.pcwrite || (in_fetch && mem_ready);
   assign pcwritecond = ctl.pcwritecond;
   assign brtype      = ctl.brtype;
   assign iord        = ctl.iord;
   assign memread     = ctl.memread;
   assign memwrite    = ctl.memwrite;
   assign memtoreg    = ctl.memtoreg;
   assign regwrite    = ctl.regwrite;
   assign regdest     = ctl.regdest;
   assign link        = ctl.link;
   assign alusrca     = ctl.alusrca;
   assign alusrcb     = ctl.alusrcb;
   assign aluop       = ctl.aluop;
   assign pcsource    = ctl.pcsource;
   assign illegal     = ctl.illegal;
   assign fault       = ctl.fault;
   assign state       = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction streams against an instruction-level phase model.
`timescale 1ns/1ps
module tb_multicycle_control;
   import mc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT a: defaults (EN_EXT=1, MEM_TIMEOUT=15); DUT b: EN_EXT=0, MEM_TIMEOUT=0
   logic       rst_a, rdy_a, rst_b, rdy_b;
   logic [5:0] op_a, op_b;
   logic       a_pcw, a_pcwc, a_brt, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rw, a_rd, a_lnk, a_asa, a_ill, a_flt;
   logic       b_pcw, b_pcwc, b_brt, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rw, b_rd, b_lnk, b_asa, b_ill, b_flt;
   logic [1:0] a_asb, a_aop, a_psrc, b_asb, b_aop, b_psrc;
   logic [3:0] a_state, b_state;
   logic [19:0] a_ctl, b_ctl;

   assign a_ctl = {a_pcw, a_pcwc, a_brt, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rw, a_rd, a_lnk, a_asa,
                   a_asb, a_aop, a_psrc, a_ill, a_flt};
   assign b_ctl = {b_pcw, b_pcwc, b_brt, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rw, b_rd, b_lnk, b_asa,
                   b_asb, b_aop, b_psrc, b_ill, b_flt};

   multicycle_control dut_a (
      .clk(clk), .reset(rst_a), .op(op_a), .mem_ready(rdy_a),
      .pcwrite(a_pcw), .pcwritecond(a_pcwc), .brtype(a_brt), .iord(a_iord), .memread(a_mrd),
      .memwrite(a_mwr), .irwrite(a_irw), .memtoreg(a_m2r), .regwrite(a_rw), .regdest(a_rd),
      .link(a_lnk), .alusrca(a_asa), .alusrcb(a_asb), .aluop(a_aop), .pcsource(a_psrc),
      .illegal(a_ill), .fault(a_flt), .state(a_state)
   );

   multicycle_control #(.MEM_TIMEOUT(0), .EN_EXT(0), .CNTW(4)) dut_b (
      .clk(clk), .reset(rst_b), .op(op_b), .mem_ready(rdy_b),
      .pcwrite(b_pcw), .pcwritecond(b_pcwc), .brtype(b_brt), .iord(b_iord), .memread(b_mrd),
      .memwrite(b_mwr), .irwrite(b_irw), .memtoreg(b_m2r), .regwrite(b_rw), .regdest(b_rd),
      .link(b_lnk), .alusrca(b_asa), .alusrcb(b_asb), .aluop(b_aop), .pcsource(b_psrc),
      .illegal(b_ill), .fault(b_flt), .state(b_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Signal-by-signal view of the control rules: each output as a predicate over phase/op.
   function automatic logic [19:0] exp_ctl(input mc_state_t s, input logic [5:0] o, input logic rdy);
      logic f, pcw, pcwc, brt, iord, mrd, mwr, irw, m2r, rw, rd, lnk, asa, ill, flt;
      logic [1:0] asb, aop, psrc;
      f    = (s == FETCH);
      pcw  = (f && rdy) || (s == JUMP);
      pcwc = (s == BRANCH);
      brt  = (s == BRANCH) && (o == 6'd38);
      iord = (s == MEMREAD) || (s == MEMWRITE);
      mrd  = f || (s == MEMREAD);
      mwr  = (s == MEMWRITE);
      irw  = f && rdy;
      m2r  = (s == MEMWB);
      rw   = (s == MEMWB) || (s == ALUWB) || ((s == JUMP) && (o == 6'd3));
      rd   = (s == ALUWB) && (o == 6'd0);
      lnk  = (s == JUMP) && (o == 6'd3);
      asa  = (s == MEMADDR) || (s == EXEC) || (s == BRANCH);
      asb  = f ? 2'b01 : (s == DECODE) ? 2'b11 :
             ((s == MEMADDR) || ((s == EXEC) && (o == 6'd13))) ? 2'b10 : 2'b00;
      aop  = (s == EXEC) ? ((o == 6'd13) ? 2'b11 : 2'b10) : (s == BRANCH) ? 2'b01 : 2'b00;
      psrc = (s == BRANCH) ? 2'b01 : (s == JUMP) ? ((o == 6'd18) ? 2'b11 : 2'b10) : 2'b00;
      ill  = (s == TRAP);
      flt  = (s == FAULT);
      return {pcw, pcwc, brt, iord, mrd, mwr, irw, m2r, rw, rd, lnk, asa, asb, aop, psrc, ill, flt};
   endfunction

   // Instruction class: 0 trap, 1 load, 2 store, 3 alu, 4 branch, 5 jump
   function automatic int op_class(input logic [5:0] o, input bit ext);
      if (o == 6'd35) return 1;
      if (o == 6'd43) return 2;
      if (o == 6'd0 || o == 6'd13) return 3;
      if (o == 6'd4 || (ext && o == 6'd38)) return 4;
      if (ext && (o == 6'd3 || o == 6'd18)) return 5;
      return 0;
   endfunction

   // One FSM cycle: drive mem_ready, check at the falling edge, return just after the rising edge.
   task automatic step(input bit b, input mc_state_t s, input logic rdy, input string tag);
      logic [5:0] o;
      if (b) rdy_b = rdy; else rdy_a = rdy;
      @(negedge clk);
      o = b ? op_b : op_a;
      check({tag, "/state"}, 32'(b ? b_state : a_state), 32'(s));
      check({tag, "/ctl"}, 32'(b ? b_ctl : a_ctl), 32'(exp_ctl(s, o, rdy)));
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input bit b, input logic [5:0] o);
      if (b) op_b = o; else op_a = o;
   endtask

   task automatic do_reset(input bit b);
      if (b) rst_b = 1'b1; else rst_a = 1'b1;
      #2;
      check("reset/state", 32'(b ? b_state : a_state), 32'(IDLE));
      check("reset/ctl", 32'(b ? b_ctl : a_ctl), 32'd0);
      @(posedge clk);
      #1;
      if (b) rst_b = 1'b0; else rst_a = 1'b0;
      step(b, IDLE, 1'($urandom), "idle");
   endtask

   // Expands one instruction into its expected phase sequence; wf/wm are memory wait cycles.
   task automatic run_instr(input bit b, input logic [5:0] o, input int wf, input int wm);
      int cls;
      cls = op_class(o, !b);
      for (int i = 0; i < wf; i++) begin
         set_op(b, 6'($urandom));
         step(b, FETCH, 1'b0, "fetch_wait");
      end
      set_op(b, o);
      step(b, FETCH, 1'b1, "fetch");
      step(b, DECODE, 1'($urandom), "decode");
      case (cls)
         1: begin
            step(b, MEMADDR, 1'($urandom), "memaddr");
            for (int i = 0; i < wm; i++) step(b, MEMREAD, 1'b0, "memread_wait");
            step(b, MEMREAD, 1'b1, "memread");
            step(b, MEMWB, 1'($urandom), "memwb");
         end
         2: begin
            step(b, MEMADDR, 1'($urandom), "memaddr");
            for (int i = 0; i < wm; i++) step(b, MEMWRITE, 1'b0, "memwrite_wait");
            step(b, MEMWRITE, 1'b1, "memwrite");
         end
         3: begin
            step(b, EXEC, 1'($urandom), "exec");
            step(b, ALUWB, 1'($urandom), "aluwb");
         end
         4: step(b, BRANCH, 1'($urandom), "branch");
         5: step(b, JUMP, 1'($urandom), "jump");
         default: begin
            for (int i = 0; i < 20; i++) step(b, TRAP, 1'($urandom), "trap");
            do_reset(b);
         end
      endcase
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] ops [8];
      ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd13, 6'd3, 6'd18, 6'd38};
      if ($urandom_range(0, 9) == 0) return 6'($urandom);
      return ops[$urandom_range(0, 7)];
   endfunction

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1; op_a = 6'd0; op_b = 6'd0;
      #2;
      check("por_a/state", 32'(a_state), 32'(IDLE));
      check("por_a/ctl", 32'(a_ctl), 32'd0);
      check("por_b/ctl", 32'(b_ctl), 32'd0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      step(1'b0, IDLE, 1'b1, "idle");

      // Directed scenarios on the full-featured instance
      run_instr(1'b0, 6'd0, 0, 0);
      run_instr(1'b0, 6'd35, 0, 3);
      run_instr(1'b0, 6'd38, 0, 0);
      run_instr(1'b0, 6'd3, 0, 0);
      run_instr(1'b0, 6'd18, 0, 0);
      run_instr(1'b0, 6'd43, 15, 15);

      for (int n = 0; n < 40; n++)
         run_instr(1'b0, pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));

      // Stuck memory: 16 FETCH cycles then FAULT, held until reset
      for (int i = 0; i < 16; i++) step(1'b0, FETCH, 1'b0, "to_fetch");
      for (int i = 0; i < 5; i++) step(1'b0, FAULT, 1'($urandom), "fault");
      do_reset(1'b0);
      run_instr(1'b0, 6'd13, 15, 0);

      // Asynchronous reset while a store is waiting on memory
      set_op(1'b0, 6'd43);
      step(1'b0, FETCH, 1'b1, "sw_fetch");
      step(1'b0, DECODE, 1'b0, "sw_decode");
      step(1'b0, MEMADDR, 1'b0, "sw_memaddr");
      step(1'b0, MEMWRITE, 1'b0, "sw_memwrite");
      rdy_a = 1'b0;
      #2;
      check("pre_rst/memwrite", 32'(a_mwr), 32'd1);
      rst_a = 1'b1;
      #1;
      check("async_rst/memwrite", 32'(a_mwr), 32'd0);
      check("async_rst/state", 32'(a_state), 32'(IDLE));
      @(posedge clk); #1;
      rst_a = 1'b0;
      step(1'b0, IDLE, 1'b0, "post_rst_idle");
      run_instr(1'b0, 6'd4, 2, 0);

      // Reduced instance: no extensions, timeout disabled
      rst_a = 1'b1;
      rst_b = 1'b0;
      step(1'b1, IDLE, 1'b1, "b_idle");
      run_instr(1'b1, 6'd35, 40, 20);
      run_instr(1'b1, 6'd38, 0, 0);
      run_instr(1'b1, 6'd3, 0, 0);
      run_instr(1'b1, 6'd4, 0, 0);
      for (int n = 0; n < 12; n++)
         run_instr(1'b1, pick_op(), $urandom_range(0, 20), $urandom_range(0, 20));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS-lite main control unit; next generation after the single-cycle decoder.
- Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Drives datapath mux selects, register-file, IR and PC write strobes, with a memory-ready handshake and wait timeout.
- Adds sticky illegal-opcode and memory-fault traps.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles with mem_ready low before FAULT; 0 disables the timeout.
- EN_EXT, 1: enables jal/jsp/bgtz decode; when 0 these opcodes are illegal.
- CNTW, 4: wait-counter width; must satisfy 2^CNTW > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- op  in  6  opcode field from IR, stable from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  conditional PC write (branch)
- brtype  out  1  0=beq (zero), 1=bgtz (positive)
- iord  out  1  memory address select, 0=PC, 1=ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load
- memtoreg  out  1  writeback data select, 1=MDR
- regwrite  out  1  register-file write
- regdest  out  1  1=rd, 0=rt
- link  out  1  write PC+4 to $31 (jal)
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- aluop  out  2  00=add, 01=sub, 10=funct, 11=nor-imm
- pcsource  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=stack target
- illegal  out  1  sticky illegal-opcode trap
- fault  out  1  sticky memory-timeout trap
- state  out  4  current state encoding (debug)

Behaviour:
- Opcodes: R=0, lw=35, sw=43, beq=4, nori=13, jal=3, jsp=18, bgtz=38.
- Reset (asynchronous): state=IDLE and wait_cnt=0. Every output is 0 while in IDLE.
- An output not listed for a state is 0 in that state.
- IDLE: no outputs asserted. Next state is FETCH.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite equal mem_ready (Mealy).
  - On mem_ready go to DECODE; otherwise stay.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00.
  - Next state by op: lw/sw to MEMADDR; R/nori to EXEC; beq/bgtz to BRANCH; jal/jsp to JUMP.
  - Any other op goes to TRAP. bgtz/jal/jsp also go to TRAP when EN_EXT=0.
- MEMADDR: alusrca=1, alusrcb=10, aluop=00. lw goes to MEMREAD; sw goes to MEMWRITE.
- MEMREAD: memread=1, iord=1. On mem_ready go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdest=0. Next state is FETCH.
- MEMWRITE: memwrite=1, iord=1. On mem_ready go to FETCH.
- EXEC: alusrca=1. R uses alusrcb=00, aluop=10; nori uses alusrcb=10, aluop=11. Next state is ALUWB.
- ALUWB: regwrite=1, memtoreg=0, regdest=(op==R). Next state is FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01.
  - brtype=(op==bgtz). Next state is FETCH.
- JUMP:
  - pcwrite=1; pcsource=10 for jal, 11 for jsp.
  - jal also asserts regwrite=1 and link=1. Next state is FETCH.
- TRAP: illegal=1. Stays until reset.
- FAULT: fault=1. Stays until reset.
- Wait counter (memory states FETCH, MEMREAD, MEMWRITE):
  - Cleared on entry to any memory state.
  - Increments each cycle the FSM is in a memory state with mem_ready=0; saturates.
  - If wait_cnt==MEM_TIMEOUT and mem_ready=0, the next state is FAULT; memory strobes stay asserted in that cycle.
  - If mem_ready=1 in the same cycle the counter reaches the limit, ready wins and the FSM proceeds normally.
  - MEM_TIMEOUT=0: the counter is ignored and the FSM never enters FAULT.
- Latencies with zero memory wait: R/nori 4 cycles, lw 5, sw 4, branch 3, jump 3, counted FETCH to return to FETCH.
- Reset mid-operation: immediate return to IDLE; pending memory strobes drop in the same cycle; traps clear.
- Unused state encodings go to IDLE on the next clock.

Decomposition:
- Shared package mc_pkg holds:
  - state enumeration: IDLE, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, BRANCH, JUMP, TRAP, FAULT.
  - opcode constants.
  - aluop, alusrcb and pcsource codes.
- One sub-module, mc_wait_timer: clear, count-enable, saturating counter, expired flag; parametrised by MEM_TIMEOUT and CNTW.

Test Plan:
- Reset released, mem_ready=1, op=0 -> state sequence IDLE, FETCH, DECODE, EXEC, ALUWB, FETCH; ALUWB shows regwrite=1, regdest=1, aluop=10 in EXEC.
- op=35, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with memread=1 and iord=1; then MEMWB with regwrite=1, memtoreg=1.
- op=38 with EN_EXT=1 -> BRANCH with pcwritecond=1, brtype=1. Same op with EN_EXT=0 -> TRAP, illegal=1 held through 20 cycles until reset.
- op=3 -> JUMP with pcwrite=1, pcsource=10, regwrite=1, link=1. op=18 -> pcsource=11, regwrite=0.
- MEM_TIMEOUT=15, mem_ready stuck 0 in FETCH -> FAULT on the 17th FSM clock after entering FETCH (16 FETCH cycles), fault=1. Repeat with mem_ready=1 on the 16th FETCH cycle -> DECODE, no fault.
- Reset asserted mid-MEMWRITE -> memwrite drops to 0 asynchronously, state=IDLE; after release the FSM refetches.
